// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helpers
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    STT_IDLE,
    STT_START,
    STT_DATA,
    STT_STOP,
    STT_BREAK
  } rx_state_t;

  // Clocks per bit (integer divide)
  function automatic int unsigned pulse_width(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

  function automatic int unsigned half_pulse_width(input int unsigned clk_freq,
                                                   input int unsigned baud_rate);
    return pulse_width(clk_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: mid-bit sampling, LSB first, stop-bit check,
// word presented on a valid/ready handshake with frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ   = 100_000_000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int unsigned PULSE_WIDTH      = pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_PULSE_WIDTH = half_pulse_width(CLK_FREQ, BAUD_RATE);
  localparam int unsigned CNT_W            = $clog2(PULSE_WIDTH) + 1;
  localparam int unsigned BIT_W            = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic rx_s;

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  valid_d, frame_err_d, overrun_d;

  // Reset to idle-high so reset never looks like a start bit
  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rx_sig),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= STT_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data      <= data_d;
      valid     <= valid_d;
      frame_err <= frame_err_d;
      overrun   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data;
    valid_d     = valid;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // Consumer handshake; a same-edge delivery below overrides this
    if (valid && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      STT_IDLE: begin
        if (!rx_s) begin
          state_d   = STT_START;
          clk_cnt_d = CNT_W'(HALF_PULSE_WIDTH - 1);
        end
      end

      STT_START: begin
        if (clk_cnt_q == '0) begin
          if (!rx_s) begin
            state_d   = STT_DATA;
            clk_cnt_d = CNT_W'(PULSE_WIDTH - 1);
            bit_cnt_d = '0;
          end else begin
            state_d = STT_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end

      STT_DATA: begin
        if (clk_cnt_q == '0) begin
          shreg_d[bit_cnt_q] = rx_s;
          clk_cnt_d          = CNT_W'(PULSE_WIDTH - 1);
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
            state_d = STT_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end

      STT_STOP: begin
        if (clk_cnt_q == '0) begin
          if (rx_s) begin
            state_d = STT_IDLE;
            if (!valid || ready) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = STT_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CNT_W'(1);
        end
      end

      STT_BREAK: begin
        if (rx_s) begin
          state_d = STT_IDLE;
        end
      end

      default: state_d = STT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: the line, reset and ready are prebuilt per cycle from a
// frame list; a word-level model predicts valid/data/frame_err/overrun.
module tb_uart_rx;

  localparam int unsigned DW  = 8;
  localparam int unsigned CF  = 1_000_000;
  localparam int unsigned BR  = 100_000;
  localparam int unsigned PW  = CF / BR;
  localparam int unsigned HPW = PW / 2;
  localparam int unsigned LAT = 2 + HPW + (DW + 1) * PW;

  logic          clk = 1'b0;
  logic          rstn;
  logic          rx_sig;
  logic          ready;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          overrun;

  uart_rx #(
    .DATA_WIDTH(DW),
    .BAUD_RATE (BR),
    .CLK_FREQ  (CF)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx_sig   (rx_sig),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned   at;
    bit            good;
    logic [DW-1:0] w;
  } ev_t;

  bit  line_q[$];
  bit  rst_q[$];
  bit  rdy_q[$];
  ev_t ev_q[$];
  int  rdy_mode;
  int  n_checks = 0;
  int  n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // One cycle of stimulus; ready follows rdy_mode (0 high, 1 low, else random)
  task automatic push_cyc(input bit v, input bit r);
    line_q.push_back(v);
    rst_q.push_back(r);
    case (rdy_mode)
      0:       rdy_q.push_back(1'b1);
      1:       rdy_q.push_back(1'b0);
      default: rdy_q.push_back(1'($urandom_range(1, 0)));
    endcase
  endtask

  task automatic add_frame(input logic [DW-1:0] w, input bit stop_ok, input int hold_low,
                           input int gap, input bit expect_ev, output int unsigned s);
    bit b;
    s = line_q.size();
    for (int k = 0; k < int'(DW) + 2; k++) begin
      if (k == 0)                b = 1'b0;
      else if (k == int'(DW) + 1) b = stop_ok;
      else                       b = w[k-1];
      for (int c = 0; c < int'(PW); c++) push_cyc(b, 1'b0);
    end
    repeat (hold_low) push_cyc(1'b0, 1'b0);
    repeat (gap) push_cyc(1'b1, 1'b0);
    if (expect_ev) ev_q.push_back('{s + LAT, stop_ok, w});
  endtask

  initial begin
    int unsigned   s, s2;
    bit            mvalid;
    logic [DW-1:0] mdata;
    bit            merr, movr, hit;
    ev_t           ev;

    // Reset and idle
    rdy_mode = 0;
    repeat (5) push_cyc(1'b1, 1'b1);
    repeat (5) push_cyc(1'b1, 1'b0);

    // Single frame, ready high
    add_frame(8'hA5, 1'b1, 0, 5, 1'b1, s);

    // Short glitch: no activity expected
    repeat (3) push_cyc(1'b0, 1'b0);
    repeat (20) push_cyc(1'b1, 1'b0);

    // Bad stop bit, line held low, then a good frame
    add_frame(8'h3C, 1'b0, 50, 5, 1'b1, s);
    add_frame(8'h55, 1'b1, 0, 5, 1'b1, s);

    // ready low: second frame overruns, then drain
    rdy_mode = 1;
    add_frame(8'h11, 1'b1, 0, 0, 1'b1, s);
    add_frame(8'h22, 1'b1, 0, 3, 1'b1, s);
    rdy_mode = 0;
    repeat (5) push_cyc(1'b1, 1'b0);

    // ready exactly at the second completion edge
    rdy_mode = 1;
    add_frame(8'h11, 1'b1, 0, 0, 1'b1, s);
    add_frame(8'h22, 1'b1, 0, 5, 1'b1, s2);
    rdy_q[s2 + LAT] = 1'b1;
    rdy_mode = 0;
    repeat (5) push_cyc(1'b1, 1'b0);

    // Reset pulse mid data bit 4 of 0xFF, then a clean frame
    add_frame(8'hFF, 1'b1, 0, 10, 1'b0, s);
    rst_q[s + 5 * PW + HPW] = 1'b1;
    add_frame(8'h81, 1'b1, 0, 5, 1'b1, s);

    // Random frames, gaps, stop errors and ready
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(99, 0) < 15)
        add_frame(8'($urandom), 1'b0, int'($urandom_range(30, 0)), 4 + int'($urandom_range(6, 0)), 1'b1, s);
      else
        add_frame(8'($urandom), 1'b1, 0, int'($urandom_range(15, 0)), 1'b1, s);
    end
    rdy_mode = 0;
    repeat (20) push_cyc(1'b1, 1'b0);

    mvalid = 1'b0;
    mdata  = '0;
    for (int i = 0; i < line_q.size(); i++) begin
      rx_sig = line_q[i];
      rstn   = !rst_q[i];
      ready  = rdy_q[i];
      @(posedge clk);
      merr = 1'b0;
      movr = 1'b0;
      hit  = (ev_q.size() > 0) && (ev_q[0].at == i);
      if (hit) ev = ev_q.pop_front();
      if (rst_q[i]) begin
        mvalid = 1'b0;
        mdata  = '0;
      end else if (hit && ev.good) begin
        if (!mvalid || rdy_q[i]) begin
          mdata  = ev.w;
          mvalid = 1'b1;
        end else begin
          movr = 1'b1;
        end
      end else begin
        if (hit) merr = 1'b1;
        if (mvalid && rdy_q[i]) mvalid = 1'b0;
      end
      @(negedge clk);
      check_eq("valid", 32'(valid), 32'(mvalid));
      check_eq("data", 32'(data), 32'(mdata));
      check_eq("frame_err", 32'(frame_err), 32'(merr));
      check_eq("overrun", 32'(overrun), 32'(movr));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
